// File: rtl/am_insertion_scheduler_if.sv
// Block-stream handshake and sequencing bundle between the AM insertion
// scheduler (master) and the surrounding datapath (slave).
interface am_insertion_scheduler_if #(
  parameter int AM_BLOCKS = 4,
  parameter int CNT_W     = 13,
  parameter int PER_W     = 16
);
  localparam int AM_W = (AM_BLOCKS > 1) ? $clog2(AM_BLOCKS) : 1;

  logic             i_enable;
  logic             i_data_valid;
  logic             o_data_ready;
  logic             i_out_ready;
  logic             o_block_valid;
  logic             o_sel_am;
  logic [AM_W-1:0]  o_am_idx;
  logic             o_sync;
  logic [CNT_W-1:0] o_block_cnt;
  logic [PER_W-1:0] o_period_cnt;

  modport master (
    input  i_enable, i_data_valid, i_out_ready,
    output o_data_ready, o_block_valid, o_sel_am, o_am_idx, o_sync,
           o_block_cnt, o_period_cnt
  );

  modport slave (
    output i_enable, i_data_valid, i_out_ready,
    input  o_data_ready, o_block_valid, o_sel_am, o_am_idx, o_sync,
           o_block_cnt, o_period_cnt
  );
endinterface

// File: rtl/am_insertion_scheduler.sv
// Splits one flow's block stream into AM periods: AM_BLOCKS marker blocks
// followed by payload blocks, BLOCKS_REPETITION blocks per period in total.
module am_insertion_scheduler #(
  parameter int BLOCKS_REPETITION = 8192,
  parameter int AM_BLOCKS         = 4,
  parameter int CNT_W             = 13,
  parameter int PER_W             = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  am_insertion_scheduler_if.master sif
);
  localparam int AM_W = (AM_BLOCKS > 1) ? $clog2(AM_BLOCKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCKS_REPETITION - 1);
  localparam logic [AM_W-1:0]  AM_LAST  = AM_W'(AM_BLOCKS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AM   = 2'd1,
    S_DATA = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] block_cnt_q, block_cnt_d;
  logic [AM_W-1:0]  am_idx_q, am_idx_d;
  logic [PER_W-1:0] period_cnt_q, period_cnt_d;

  logic blk_valid;
  logic data_ready;
  logic sel_am;
  logic sync;
  logic xfer;

  // Handshake outputs decode from state; payload side is a pure pass-through.
  always_comb begin
    blk_valid  = 1'b0;
    data_ready = 1'b0;
    sel_am     = 1'b0;
    sync       = 1'b0;
    case (state_q)
      S_AM: begin
        blk_valid = 1'b1;
        sel_am    = 1'b1;
        sync      = (am_idx_q == AM_W'(0));
      end
      S_DATA: begin
        blk_valid  = sif.i_data_valid;
        data_ready = sif.i_out_ready;
      end
      default: begin
        blk_valid = 1'b0;
      end
    endcase
  end

  assign xfer = blk_valid & sif.i_out_ready;

  // Next-state and counter update; a disable wins over a concurrent transfer.
  always_comb begin
    state_d      = state_q;
    block_cnt_d  = block_cnt_q;
    am_idx_d     = am_idx_q;
    period_cnt_d = period_cnt_q;
    case (state_q)
      S_IDLE: begin
        block_cnt_d  = CNT_W'(0);
        am_idx_d     = AM_W'(0);
        period_cnt_d = PER_W'(0);
        if (sif.i_enable) begin
          state_d = S_AM;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_AM: begin
        if (!sif.i_enable) begin
          state_d      = S_IDLE;
          block_cnt_d  = CNT_W'(0);
          am_idx_d     = AM_W'(0);
          period_cnt_d = PER_W'(0);
        end else if (xfer) begin
          block_cnt_d = block_cnt_q + CNT_W'(1);
          if (am_idx_q == AM_LAST) begin
            state_d  = S_DATA;
            am_idx_d = AM_W'(0);
          end else begin
            am_idx_d = am_idx_q + AM_W'(1);
          end
        end else begin
          state_d = S_AM;
        end
      end
      S_DATA: begin
        if (!sif.i_enable) begin
          state_d      = S_IDLE;
          block_cnt_d  = CNT_W'(0);
          am_idx_d     = AM_W'(0);
          period_cnt_d = PER_W'(0);
        end else if (xfer) begin
          if (block_cnt_q == CNT_LAST) begin
            state_d      = S_AM;
            block_cnt_d  = CNT_W'(0);
            period_cnt_d = period_cnt_q + PER_W'(1);
          end else begin
            block_cnt_d = block_cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = S_DATA;
        end
      end
      default: begin
        state_d      = S_IDLE;
        block_cnt_d  = CNT_W'(0);
        am_idx_d     = AM_W'(0);
        period_cnt_d = PER_W'(0);
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      block_cnt_q  <= CNT_W'(0);
      am_idx_q     <= AM_W'(0);
      period_cnt_q <= PER_W'(0);
    end else begin
      state_q      <= state_d;
      block_cnt_q  <= block_cnt_d;
      am_idx_q     <= am_idx_d;
      period_cnt_q <= period_cnt_d;
    end
  end

  assign sif.o_block_valid = blk_valid;
  assign sif.o_data_ready  = data_ready;
  assign sif.o_sel_am      = sel_am;
  assign sif.o_sync        = sync;
  assign sif.o_am_idx      = am_idx_q;
  assign sif.o_block_cnt   = block_cnt_q;
  assign sif.o_period_cnt  = period_cnt_q;
endmodule

// File: tb/tb_am_insertion_scheduler.sv
// Directed bench for am_insertion_scheduler with an 8-block period, 4 AM
// blocks and a 2-bit period counter so the wrap is reached quickly.
module tb_am_insertion_scheduler;
  localparam int REP   = 8;
  localparam int AMB   = 4;
  localparam int CNT_W = 3;
  localparam int PER_W = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  am_insertion_scheduler_if #(.AM_BLOCKS(AMB), .CNT_W(CNT_W), .PER_W(PER_W)) sif ();

  am_insertion_scheduler #(
    .BLOCKS_REPETITION(REP),
    .AM_BLOCKS        (AMB),
    .CNT_W            (CNT_W),
    .PER_W            (PER_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .sif (sif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic exp_out(input string tag, input logic v, input logic r, input logic s,
                         input int idx, input logic sy, input int cnt, input int per);
    chk({tag, ".valid"},  32'(sif.o_block_valid), 32'(v));
    chk({tag, ".ready"},  32'(sif.o_data_ready),  32'(r));
    chk({tag, ".sel_am"}, 32'(sif.o_sel_am),      32'(s));
    chk({tag, ".am_idx"}, 32'(sif.o_am_idx),      32'(idx));
    chk({tag, ".sync"},   32'(sif.o_sync),        32'(sy));
    chk({tag, ".cnt"},    32'(sif.o_block_cnt),   32'(cnt));
    chk({tag, ".per"},    32'(sif.o_period_cnt),  32'(per));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   pos;
    int   exp_cnt;
    logic p_sel;
    logic [6:0] gap_pat;

    sif.i_enable     = 1'b0;
    sif.i_data_valid = 1'b0;
    sif.i_out_ready  = 1'b0;
    #1 rst = 1'b1;
    #2;
    exp_out("reset", 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 0);

    @(negedge clk);
    rst = 1'b0;
    sif.i_enable     = 1'b1;
    sif.i_data_valid = 1'b1;
    sif.i_out_ready  = 1'b1;
    #1;
    exp_out("idle_pre", 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 0);

    // Free-running: five full periods plus the first block of the sixth.
    for (int k = 0; k <= 40; k++) begin
      cyc();
      pos   = k % REP;
      p_sel = (pos < AMB);
      exp_out($sformatf("run%0d", k), 1'b1, ~p_sel, p_sel, p_sel ? pos : 0,
              (pos == 0), pos, (k / REP) % 4);
    end

    // Stall during AM block 2.
    cyc();
    cyc();
    exp_out("am2", 1'b1, 1'b0, 1'b1, 2, 1'b0, 2, 1);
    sif.i_out_ready = 1'b0;
    #1;
    exp_out("stall0", 1'b1, 1'b0, 1'b1, 2, 1'b0, 2, 1);
    for (int i = 1; i <= 3; i++) begin
      cyc();
      exp_out($sformatf("stall%0d", i), 1'b1, 1'b0, 1'b1, 2, 1'b0, 2, 1);
    end
    sif.i_out_ready = 1'b1;
    #1;
    exp_out("resume", 1'b1, 1'b0, 1'b1, 2, 1'b0, 2, 1);
    cyc();
    exp_out("am3", 1'b1, 1'b0, 1'b1, 3, 1'b0, 3, 1);
    cyc();
    exp_out("data4", 1'b1, 1'b1, 1'b0, 0, 1'b0, 4, 1);

    // Gapped upstream valid in DATA.
    gap_pat = 7'b1010101;
    exp_cnt = 4;
    for (int i = 0; i < 7; i++) begin
      sif.i_data_valid = gap_pat[i];
      #1;
      exp_out($sformatf("gap%0d", i), gap_pat[i], 1'b1, 1'b0, 0, 1'b0, exp_cnt, 1);
      if (gap_pat[i]) exp_cnt++;
      cyc();
    end
    sif.i_data_valid = 1'b1;
    #1;
    exp_out("gap_wrap", 1'b1, 1'b0, 1'b1, 0, 1'b1, 0, 2);

    // Disable at block 6, then re-enable.
    for (int i = 0; i < 6; i++) cyc();
    exp_out("cnt6", 1'b1, 1'b1, 1'b0, 0, 1'b0, 6, 2);
    sif.i_enable = 1'b0;
    #1;
    exp_out("dis_xfer", 1'b1, 1'b1, 1'b0, 0, 1'b0, 6, 2);
    cyc();
    exp_out("dis_idle", 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 0);
    cyc();
    exp_out("idle_hold", 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 0);
    sif.i_enable = 1'b1;
    #1;
    exp_out("reen_pre", 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 0);
    cyc();
    exp_out("reen_am0", 1'b1, 1'b0, 1'b1, 0, 1'b1, 0, 0);

    // Asynchronous reset in the middle of DATA.
    for (int i = 0; i < 5; i++) cyc();
    exp_out("pre_rst", 1'b1, 1'b1, 1'b0, 0, 1'b0, 5, 0);
    #3;
    rst = 1'b1;
    #1;
    exp_out("async_rst", 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 0);
    cyc();
    exp_out("rst_hold", 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 0);
    #3;
    rst = 1'b0;
    cyc();
    exp_out("post_rst", 1'b1, 1'b0, 1'b1, 0, 1'b1, 0, 0);
    cyc();
    exp_out("post_rst1", 1'b1, 1'b0, 1'b1, 1, 1'b0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/am_insertion_scheduler.md
# am_insertion_scheduler

Sequences the 257-bit block stream of one flow into alignment-marker (AM) periods. Each period of BLOCKS_REPETITION blocks starts with AM_BLOCKS AM blocks, followed by payload blocks taken from upstream. The block drives the AM/data mux select, the AM block index, the per-period sync strobe and the valid/ready handshakes on both sides. It sits between the scrambled-data source and the AM mapping / codeword-lane distribution datapath.

## Interface
- BLOCKS_REPETITION, 8192: total blocks per AM period, AM blocks included; must be greater than AM_BLOCKS.
- AM_BLOCKS, 4: number of AM blocks at the start of each period (4 × 257 bits covers the 1028-bit mapped AM).
- CNT_W, 13: width of the block counter; 2^CNT_W ≥ BLOCKS_REPETITION.
- PER_W, 16: width of the period counter.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- i_enable  in  1  run request, level-sensitive.
- i_data_valid  in  1  upstream has a payload block.
- o_data_ready  out  1  upstream block is accepted this cycle.
- i_out_ready  in  1  downstream accepts a block this cycle.
- o_block_valid  out  1  a block is presented downstream this cycle.
- o_sel_am  out  1  1 = downstream mux selects AM block; 0 = selects payload.
- o_am_idx  out  clog2(AM_BLOCKS)  index of the AM block presented, 0..AM_BLOCKS-1; 0 outside AM.
- o_sync  out  1  high while AM block 0 is presented (period start marker).
- o_block_cnt  out  CNT_W  position in period of the block presented, 0..BLOCKS_REPETITION-1.
- o_period_cnt  out  PER_W  completed periods, wraps modulo 2^PER_W.

## Operation
- States: IDLE, AM, DATA. Registered: state, o_block_cnt, o_am_idx, o_period_cnt.
- A transfer is a cycle with o_block_valid && i_out_ready.
- IDLE:
  - All handshake outputs are 0.
  - i_enable=1 → AM next cycle, with block_cnt=0 and am_idx=0.
- AM:
  - Outputs: o_block_valid=1, o_sel_am=1, o_data_ready=0. o_sync=(am_idx==0).
  - On each transfer, am_idx and block_cnt increment.
  - A transfer with am_idx==AM_BLOCKS-1 → DATA, am_idx=0.
- DATA:
  - Outputs: o_sel_am=0, o_block_valid=i_data_valid, o_data_ready=i_out_ready (combinational pass-through).
  - On each transfer, block_cnt increments.
  - A transfer with block_cnt==BLOCKS_REPETITION-1 → AM, block_cnt=0, period_cnt+1 (wrap).
- Stall: without a transfer, all registers hold and the presented AM index and block position do not change.
- Disable:
  - i_enable=0 in AM or DATA → IDLE next cycle; block_cnt, am_idx and period_cnt clear.
  - A transfer in that same cycle still completes on the handshake signals but is not counted.
  - Re-enable always restarts a full period with AM block 0.
- Arithmetic:
  - block_cnt compare is exact equality against BLOCKS_REPETITION-1; no overflow path.
  - period_cnt is unsigned and wraps from 2^PER_W-1 to 0.

## Timing
- Reset values (asynchronous, immediate): state=IDLE, o_block_cnt=0, o_am_idx=0, o_period_cnt=0, o_block_valid=0, o_data_ready=0, o_sel_am=0, o_sync=0.
- Reset mid-period aborts immediately. The first block after reset release plus enable is AM block 0.
- Latency:
  - i_enable rising in IDLE → first AM block presented in the following cycle.
  - Payload path has zero cycles of handshake latency (ready/valid combinational in DATA).
- Throughput: one block per cycle when i_out_ready=1 and upstream is always valid. The period length is exactly BLOCKS_REPETITION transfers.
- Period boundary: the last payload transfer and the switch to AM block 0 occur on consecutive cycles, with no bubble.
- o_data_ready is never 1 while o_sel_am=1.
- o_sync is combinational from state; it stays high for every stalled cycle of AM block 0.

## Test plan
All scenarios use BLOCKS_REPETITION=8, AM_BLOCKS=4 unless stated.
- Reset then enable, i_out_ready=1, i_data_valid=1 → cycle pattern sel_am 1,1,1,1,0,0,0,0 repeating; am_idx 0,1,2,3; sync only on am_idx 0; block_cnt 0..7; period_cnt increments on each return to AM.
- i_out_ready=0 for 3 cycles during AM block 2 → am_idx holds at 2, block_cnt holds at 2, o_data_ready=0; resumes at 3 when ready returns.
- i_data_valid gapped (1,0,1,0) in DATA → o_block_valid follows it; block_cnt advances only on valid cycles; the period still contains exactly 4 payload transfers.
- Deassert i_enable at block_cnt=6 → IDLE next cycle, all counters 0; re-enable → am_idx 0, sync=1, block_cnt=0.
- Assert rst asynchronously mid-DATA (between clock edges) → all outputs 0 immediately, without waiting for clk.
- PER_W=2, run 5 full periods → period_cnt sequence 1,2,3,0,1.
